// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: constants shared by the traffic-light Nios II bus peripherals.
// Holds the Avalon register word addresses and the edge-select encoding of the key input port.
package traffic_light_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_ANY  = 2'd2;

  // Any encoding other than rise/fall is treated as "any edge".
  function automatic logic edge_selected(input logic cur, input logic prev, input logic [1:0] etype);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (etype)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one asynchronous pin through a 2-flop synchroniser and a stability counter.
// The debounced output only follows the pin after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  // Any sample that agrees with the current debounced level restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
      r_deb   <= IDLE_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/traffic_light_key_in.sv
// traffic_light_key_in: Avalon-MM input port for the board keys and switches.
// Debounced pins, sticky edge capture with write-1-to-clear, and a masked level interrupt.
module traffic_light_key_in
  import traffic_light_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [1:0]       EDGE_TYPE       = EDGE_FALL,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_edge_hit;
  logic [WIDTH-1:0] w_clear;
  logic             w_write;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_deb_d;
  logic [WIDTH-1:0] r_edge_capture;
  logic [WIDTH-1:0] r_irq_mask;

  assign w_write        = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata;
  assign w_clear        = (w_write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_pin
      key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_LEVEL      (IDLE_LEVEL[g])
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .i_pin   (in_port[g]),
        .o_deb   (w_deb[g])
      );
      assign w_edge_hit[g] = edge_selected(w_deb[g], r_deb_d[g], EDGE_TYPE);
    end
  endgenerate

  // A new edge in the same cycle as its W1C wins, so the event is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_d        <= IDLE_LEVEL;
      r_edge_capture <= '0;
      r_irq_mask     <= '0;
    end else begin
      r_deb_d        <= w_deb;
      r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge_hit;
      if (w_write && address == ADDR_MASK) begin
        r_irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA: readdata[WIDTH-1:0] = w_deb;
        ADDR_MASK: readdata[WIDTH-1:0] = r_irq_mask;
        ADDR_EDGE: readdata[WIDTH-1:0] = r_edge_capture;
        default:   readdata = '0;
      endcase
    end
  end

  assign irq = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_traffic_light_key_in.sv
// tb_traffic_light_key_in: scoreboard bench for the key input port (WIDTH=4, 4-cycle debounce, falling edges).
// Expected reads are queued at issue time and popped by an independent monitor on the falling clock edge.
module tb_traffic_light_key_in;

  localparam int         WIDTH = 4;
  localparam int         DC    = 4;
  localparam logic [3:0] IDLE  = 4'hF;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  in_port    = IDLE;
  logic        irq;
  logic        rdActive   = 1'b0;

  typedef struct {
    logic [31:0] rd;
    bit          chkIrq;
    logic        irqExp;
    string       name;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  // Reference model: pin sample history plus debounced, capture and mask state.
  logic [3:0] mDeb  = IDLE;
  logic [3:0] mDebD = IDLE;
  logic [3:0] mCap  = 4'h0;
  logic [3:0] mMask = 4'h0;
  logic [3:0] mFall;
  logic [3:0] mClr;
  logic [3:0] mNext;
  logic [3:0] hist[$];
  bit         allSame;
  int         last;

  always #5 clk = ~clk;

  traffic_light_key_in #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC),
    .EDGE_TYPE       (2'd1),
    .IDLE_LEVEL      (IDLE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  // A pin level is accepted once the last DC synchronised samples all agree on a new value.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mDeb  = IDLE;
      mDebD = IDLE;
      mCap  = 4'h0;
      mMask = 4'h0;
      hist.delete();
      for (int k = 0; k < DC + 1; k++) hist.push_back(IDLE);
    end else begin
      mFall = mDebD & ~mDeb;
      mClr  = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      mCap  = (mCap & ~mClr) | mFall;
      if (chipselect && !write_n && address == 2'd2) mMask = writedata[3:0];
      hist.push_back(in_port);
      last  = hist.size() - 3;
      mNext = mDeb;
      for (int b = 0; b < WIDTH; b++) begin
        allSame = 1'b1;
        for (int k = last - DC + 1; k <= last; k++)
          if (hist[k][b] != hist[last][b]) allSame = 1'b0;
        if (allSame && hist[last][b] != mDeb[b]) mNext[b] = hist[last][b];
      end
      mDebD = mDeb;
      mDeb  = mNext;
      if (hist.size() > DC + 3) void'(hist.pop_front());
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: irq against the model every cycle, and queued read expectations whenever a read is presented.
  always @(negedge clk) begin
    checkOutput("irq_model", {31'b0, irq}, {31'b0, |(mCap & mMask)});
    if (rdActive) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL queue_underflow: read presented with no expectation queued");
      end else begin
        cur = expQ.pop_front();
        checkOutput(cur.name, readdata, cur.rd);
        if (cur.chkIrq) checkOutput({cur.name, "_irq"}, {31'b0, irq}, {31'b0, cur.irqExp});
      end
    end
  end

  function automatic logic [31:0] modelRead(input logic [1:0] addr, input logic cs);
    if (!cs) return 32'd0;
    case (addr)
      2'd0:    return {28'b0, mDeb};
      2'd2:    return {28'b0, mMask};
      2'd3:    return {28'b0, mCap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] addr, input logic cs, input logic wrN,
                               input logic [31:0] wdata, input logic isRead);
    address    = addr;
    chipselect = cs;
    write_n    = wrN;
    writedata  = wdata;
    rdActive   = isRead;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'd0, 1'b0, 1'b1, 32'd0, 1'b0);
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(addr, 1'b1, 1'b0, data, 1'b0);
  endtask

  task automatic readExp(input logic [1:0] addr, input logic cs, input logic [31:0] expv,
                         input bit chkIrq, input logic irqExp, input string name);
    exp_t e;
    e.rd = expv;
    e.chkIrq = chkIrq;
    e.irqExp = irqExp;
    e.name = name;
    expQ.push_back(e);
    applyStimulus(addr, cs, 1'b1, 32'd0, 1'b1);
  endtask

  task automatic readModel(input logic [1:0] addr, input logic cs, input string name);
    readExp(addr, cs, modelRead(addr, cs), 1'b0, 1'b0, name);
  endtask

  initial begin
    $display("[TB] starting key input port bench");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idleCycles(2);

    // Reset state
    readExp(2'd0, 1'b1, 32'hF, 1'b1, 1'b0, "t1_data_reset");
    readExp(2'd3, 1'b1, 32'h0, 1'b1, 1'b0, "t1_edge_reset");
    readExp(2'd1, 1'b1, 32'h0, 1'b0, 1'b0, "t1_reserved");
    readExp(2'd0, 1'b0, 32'h0, 1'b0, 1'b0, "t1_unselected");

    // Pin 0 falls: DATA turns 0xE at t0+5, capture at t0+6, irq held off by mask
    in_port = 4'hE;
    for (int i = 0; i < 7; i++)
      readExp(2'd0, 1'b1, (i < 6) ? 32'hF : 32'hE, 1'b0, 1'b0, $sformatf("t2_data_%0d", i));
    readExp(2'd3, 1'b1, 32'h1, 1'b1, 1'b0, "t2_edge_set");

    // Mask enables irq; W1C of zero is harmless; W1C of one clears
    writeReg(2'd2, 32'h1);
    readExp(2'd2, 1'b1, 32'h1, 1'b1, 1'b1, "t3_mask_irq");
    writeReg(2'd3, 32'h0);
    readExp(2'd3, 1'b1, 32'h1, 1'b1, 1'b1, "t3_w1c_zero");
    writeReg(2'd3, 32'h1);
    readExp(2'd3, 1'b1, 32'h0, 1'b1, 1'b0, "t3_w1c_clear");

    // Short glitch on pin 1 is filtered, a full-length one is captured
    in_port = 4'hF;
    idleCycles(8);
    readExp(2'd0, 1'b1, 32'hF, 1'b0, 1'b0, "t4_restored");
    in_port = 4'hD;
    for (int i = 0; i < 3; i++) readExp(2'd0, 1'b1, 32'hF, 1'b0, 1'b0, "t4_glitch_data");
    in_port = 4'hF;
    for (int i = 0; i < 8; i++) readExp(2'd0, 1'b1, 32'hF, 1'b0, 1'b0, "t4_after_glitch");
    readExp(2'd3, 1'b1, 32'h0, 1'b0, 1'b0, "t4_short_nocap");
    in_port = 4'hD;
    for (int i = 0; i < 4; i++) readModel(2'd0, 1'b1, "t4_pulse_data");
    in_port = 4'hF;
    idleCycles(8);
    readExp(2'd3, 1'b1, 32'h2, 1'b0, 1'b0, "t4_long_cap");

    // Set of bit 2 lands in the same cycle as its W1C
    writeReg(2'd3, 32'hF);
    in_port = 4'hB;
    for (int i = 0; i < 6; i++) readExp(2'd0, 1'b1, 32'hF, 1'b0, 1'b0, "t5_wait_data");
    writeReg(2'd3, 32'h4);
    readExp(2'd3, 1'b1, 32'h4, 1'b1, 1'b0, "t5_set_wins");
    writeReg(2'd3, 32'h4);
    readExp(2'd3, 1'b1, 32'h0, 1'b0, 1'b0, "t5_clear_after");
    in_port = 4'hF;
    idleCycles(8);

    // Asynchronous reset with captures pending and a counter mid-count
    writeReg(2'd2, 32'h3);
    in_port = 4'hC;
    idleCycles(8);
    readExp(2'd3, 1'b1, 32'h3, 1'b1, 1'b1, "t6_pre_cap");
    in_port = 4'hF;
    idleCycles(3);
    #2 reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    readExp(2'd0, 1'b1, 32'hF, 1'b1, 1'b0, "t6_data_reset");
    readExp(2'd2, 1'b1, 32'h0, 1'b1, 1'b0, "t6_mask_reset");
    readExp(2'd3, 1'b1, 32'h0, 1'b1, 1'b0, "t6_edge_reset");
    idleCycles(10);
    readExp(2'd3, 1'b1, 32'h0, 1'b1, 1'b0, "t6_no_cap");

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) in_port = 4'($urandom);
      case ($urandom_range(9))
        0, 1, 2, 3: readModel(2'($urandom), ($urandom_range(7) != 0), "rand_read");
        4:          writeReg(2'd2, $urandom);
        5, 6:       writeReg(2'd3, $urandom);
        7:          writeReg(2'($urandom_range(1)), $urandom);
        default:    idleCycles(1);
      endcase
    end
    in_port = IDLE;
    idleCycles(2);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_key_in.md
# traffic_light_key_in

Avalon-MM slave input port that brings the board push-buttons and switches into the traffic-light Nios II system. It is the input-direction counterpart of the HEX/LED output ports. Each pin is synchronised and debounced, and selectable edges are captured into sticky bits. A level interrupt is raised to the CPU for unmasked captured edges.

## Interface
Parameters:
- WIDTH, 4: number of input pins (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a pin change is accepted (1 ms at 50 MHz, must be ≥1).
- EDGE_TYPE, 2'd1: edges captured. 0 = rising, 1 = falling, 2 = any.
- IDLE_LEVEL, {WIDTH{1'b1}}: reset value of the synchroniser and debounced state. Keys are active-low.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; zero wait states, read latency 0.
- in_port  in  WIDTH  raw asynchronous pins.
- irq  out  1  level interrupt, active-high.

## Operation
Register map (word addresses):
- 0 DATA: RO. Debounced pin state in bits [WIDTH-1:0]. Writes are ignored.
- 1 reserved: reads 0, writes ignored.
- 2 IRQ_MASK: RW. Bit i enables edge_capture[i] onto irq.
- 3 EDGE_CAPTURE: R/W1C. Writing 1 to bit i clears that bit; writing 0 has no effect.

Behaviour:
- readdata is combinational: zero-extended mux of the addressed register. An unselected or reserved address returns 0. Bits above WIDTH always read 0.
- A write occurs when chipselect && !write_n. Only writedata[WIDTH-1:0] is used.
- Per-pin debouncer:
  - Input is sync2, the output of a 2-flop synchroniser.
  - Counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves deb unchanged and restarts the count.
- Edge detect: deb_d is deb delayed one cycle.
  - rise = deb & ~deb_d; fall = ~deb & deb_d.
  - The selected edge sets edge_capture[i], which stays set until cleared.
- Set and W1C clear of the same bit in the same cycle: set wins and the bit stays 1.
- irq = |(edge_capture & irq_mask). It is combinational from registers and glitch-free.
- Reset values:
  - sync1, sync2, deb, deb_d = IDLE_LEVEL, so no edge is captured out of reset.
  - cnt = 0; irq_mask = 0; edge_capture = 0.
  - Therefore irq = 0 and readdata = 0 with chipselect low.
- Reset asserted mid-debounce or with pending captures: all state returns to reset values immediately (asynchronous).

## Timing
- Pin change at posedge t0 (setup met):
  - sync2 changes at t0+1.
  - deb changes at t0+DEBOUNCE_CYCLES+1.
  - edge_capture and irq assert at t0+DEBOUNCE_CYCLES+2.
- W1C at posedge t: bit reads 0 and irq deasserts from t+1 onward, unless a new edge sets it at t.
- IRQ_MASK write at t: takes effect on irq from t+1.
- DATA read reflects deb as of the current cycle.

## Structure
- Shared package traffic_light_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3;
  - edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, key_debounce: a single-bit 2-flop synchroniser plus counter, parameterised on DEBOUNCE_CYCLES and IDLE_LEVEL. It is instantiated WIDTH times with a generate loop.
- Edge capture, mask, bus decode and irq stay in the top module.

## Test plan
Benches run with WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=falling, IDLE_LEVEL=4'hF.
1. Reset, then read address 0 → 0x0000000F; read address 3 → 0; irq=0.
2. Drive in_port[0] low at t0, then read DATA each cycle → deb[0]=0 exactly at t0+5 (read 0xE). edge_capture=0x1 at t0+6; irq stays 0 with mask 0.
3. Write IRQ_MASK=0x1 → irq=1 the next cycle. Write EDGE_CAPTURE=0x1 → irq=0 the next cycle. Writing EDGE_CAPTURE=0x0 leaves it unchanged.
4. Pulse in_port[1] low for 3 cycles → DATA stays 0xF and no capture. Pulse it low for 4 cycles → capture bit 1 is set.
5. Time a falling edge to set bit 2 in the same cycle as a W1C of bit 2 → bit reads 1 afterwards.
6. Assert reset_n with cnt mid-count and edge_capture=0x3 → all registers return to reset values; no capture after release while pins are held at 0xF.
